// File: rtl/egress_rr_arbiter_pkg.sv
// Shared constants for the egress round-robin arbiter slice.
package egress_rr_arbiter_pkg;

    localparam int DATA_WIDTH = 12;
    localparam int NUM_PORTS  = 4;
    localparam int PORT_ID_W  = 2;

    // Two-state activity FSM encoding
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

endpackage

// File: rtl/egress_rr_arbiter_if.sv
// FIFO-side and egress-stream signals of the arbiter.
// master: arbiter side, slave: FIFOs + sink side.
interface egress_rr_arbiter_if #(
    parameter int DATA_WIDTH = egress_rr_arbiter_pkg::DATA_WIDTH
);
    logic [3:0]            fifo_empty;
    logic [DATA_WIDTH-1:0] data_in_p0;
    logic [DATA_WIDTH-1:0] data_in_p1;
    logic [DATA_WIDTH-1:0] data_in_p2;
    logic [DATA_WIDTH-1:0] data_in_p3;
    logic [3:0]            pop;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  ready_in;

    modport master (
        input  fifo_empty, data_in_p0, data_in_p1, data_in_p2, data_in_p3, ready_in,
        output pop, data_out, valid_out
    );

    modport slave (
        output fifo_empty, data_in_p0, data_in_p1, data_in_p2, data_in_p3, ready_in,
        input  pop, data_out, valid_out
    );
endinterface

// File: rtl/egress_out_buffer.sv
// Small register FIFO holding {port_id, data} between FIFO read and egress.
// Head entry is driven straight from storage, so the egress word is registered.
module egress_out_buffer
    import egress_rr_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = egress_rr_arbiter_pkg::DATA_WIDTH,
    parameter int BUF_DEPTH  = 2,
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1),
    localparam int PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enq,
    input  logic [PORT_ID_W-1:0]  enq_port,
    input  logic [DATA_WIDTH-1:0] enq_data,
    input  logic                  deq,
    output logic [CNT_W-1:0]      count,
    output logic [PORT_ID_W-1:0]  head_port,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_valid
);

    logic [BUF_DEPTH-1:0][DATA_WIDTH-1:0] mem_data;
    logic [BUF_DEPTH-1:0][PORT_ID_W-1:0]  mem_port;
    logic [PTR_W-1:0]                     wr_ptr;
    logic [PTR_W-1:0]                     rd_ptr;

    // Storage write and pointer/occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_data <= '0;
            mem_port <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (enq) begin
                mem_data[wr_ptr] <= enq_data;
                mem_port[wr_ptr] <= enq_port;
                wr_ptr <= (wr_ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (deq)
                rd_ptr <= (rd_ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data  = mem_data[rd_ptr];
    assign head_port  = mem_port[rd_ptr];
    assign head_valid = (count != '0);

endmodule

// File: rtl/egress_rr_arbiter.sv
// Round-robin egress arbiter: pops four port FIFOs one-hot, absorbs the
// 1-cycle FIFO read latency and sink backpressure in egress_out_buffer.
// Optional per-port delivered-word counters under EGRESS_PKT_COUNT_EN.
module egress_rr_arbiter
    import egress_rr_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = egress_rr_arbiter_pkg::DATA_WIDTH,
    parameter int BUF_DEPTH  = 2,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    egress_rr_arbiter_if.master  bus,
    output logic                 idle,
    input  logic                 req,
    input  logic [PORT_ID_W-1:0] idx,
    output logic [CNT_WIDTH-1:0] count_out,
    output logic                 count_valid
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);

    logic [PORT_ID_W-1:0]  rr_ptr;
    logic [PORT_ID_W-1:0]  cand;
    logic [PORT_ID_W-1:0]  gnt_port;
    logic                  gnt_found;
    logic                  room;
    logic                  pop_fire;
    logic                  inflight;
    logic [PORT_ID_W-1:0]  inflight_port;
    logic [DATA_WIDTH-1:0] cap_data;
    logic                  deq;
    logic [OCC_W-1:0]      occ;
    logic [PORT_ID_W-1:0]  head_port;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  head_valid;
    logic                  idle_cond;
    logic [0:0]            state;
    logic [0:0]            state_nxt;

    // First non-empty port at or after the RR pointer, wrapping 3->0
    always_comb begin
        gnt_found = 1'b0;
        gnt_port  = rr_ptr;
        cand      = rr_ptr;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = rr_ptr + PORT_ID_W'(k);
            if (!gnt_found && !bus.fifo_empty[cand]) begin
                gnt_found = 1'b1;
                gnt_port  = cand;
            end
        end
    end

    // A pop is only safe if its word will find a free slot: count what stays
    // buffered after this cycle's dequeue plus the word still in flight.
    assign deq      = head_valid & bus.ready_in;
    assign room     = (32'(occ) + 32'(inflight) - 32'(deq)) < 32'(BUF_DEPTH);
    assign pop_fire = !reset && enable && gnt_found && room;

    // One-hot pop towards the port FIFOs
    always_comb begin
        bus.pop = '0;
        if (pop_fire)
            bus.pop[gnt_port] = 1'b1;
    end

    // RR pointer and in-flight tracking across the FIFO read latency
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr        <= '0;
            inflight      <= 1'b0;
            inflight_port <= '0;
        end else begin
            inflight <= pop_fire;
            if (pop_fire) begin
                rr_ptr        <= gnt_port + PORT_ID_W'(1);
                inflight_port <= gnt_port;
            end
        end
    end

    // Select the read data of the port popped last cycle
    always_comb begin
        cap_data = bus.data_in_p0;
        case (inflight_port)
            2'd1:    cap_data = bus.data_in_p1;
            2'd2:    cap_data = bus.data_in_p2;
            2'd3:    cap_data = bus.data_in_p3;
            default: cap_data = bus.data_in_p0;
        endcase
    end

    egress_out_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_out_buf (
        .clk        (clk),
        .reset      (reset),
        .enq        (inflight),
        .enq_port   (inflight_port),
        .enq_data   (cap_data),
        .deq        (deq),
        .count      (occ),
        .head_port  (head_port),
        .head_data  (head_data),
        .head_valid (head_valid)
    );

    assign bus.valid_out = head_valid;
    assign bus.data_out  = head_data;

    assign idle_cond = !head_valid && !inflight && (&bus.fifo_empty);
    assign idle      = idle_cond;

    // Activity FSM next state; kept for observation, grant does not use it
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (enable && !(&bus.fifo_empty)) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (idle_cond) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Activity FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

`ifdef EGRESS_PKT_COUNT_EN
    logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] pkt_cnt;

    // Count accepted words per source port; wraps naturally
    always_ff @(posedge clk) begin
        if (reset)
            pkt_cnt <= '0;
        else if (deq)
            pkt_cnt[head_port] <= pkt_cnt[head_port] + CNT_WIDTH'(1);
    end

    // Counter read port: value sampled before any same-cycle increment
    always_ff @(posedge clk) begin
        if (reset) begin
            count_valid <= 1'b0;
            count_out   <= '0;
        end else begin
            count_valid <= req;
            count_out   <= req ? pkt_cnt[idx] : '0;
        end
    end
`else
    logic unused_cnt_in;
    assign unused_cnt_in = ^{req, idx, head_port};
    assign count_out     = '0;
    assign count_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_egress_rr_arbiter.sv
// Bench for egress_rr_arbiter: emulates the four port FIFOs with queues and
// predicts pops, egress words, idle and counter reads from the arbitration rules.
module tb_egress_rr_arbiter;
    import egress_rr_arbiter_pkg::*;

    localparam int BUF_DEPTH = 2;
    localparam int CNT_MOD   = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       idle;
    logic       req;
    logic [1:0] idx;
    logic [4:0] count_out;
    logic       count_valid;

    always #5 clk = ~clk;

    egress_rr_arbiter_if bus ();

    egress_rr_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .bus         (bus),
        .idle        (idle),
        .req         (req),
        .idx         (idx),
        .count_out   (count_out),
        .count_valid (count_valid)
    );

    typedef struct {
        logic [11:0] word;
        int          port;
        int          cyc;
    } sb_t;

    sb_t         sb[$];      // popped, not yet accepted, in pop order
    logic [11:0] fq[4][$];   // port FIFO contents
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          mptr  = 0;
    int          seq   = 0;
    int          cnt[4];
    bit          pend_req;
    int          pend_val;
    bit          last_vld;
    int          last_port;
    logic [11:0] last_word;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
        end
    endtask

    task automatic load(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            fq[p].push_back(12'(p * 256 + (seq % 256)));
            seq++;
        end
    endtask

    // One clock: drive FIFO side, check outputs mid-cycle, advance the model
    task automatic step();
        logic [3:0] exp_pop;
        logic [3:0] act_pop;
        bit         exp_vld;
        bit         exp_acc;
        bit         any;
        bit         all_empty;
        int         ep;
        int         ap;
        all_empty = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.fifo_empty[i] = (fq[i].size() == 0);
            if (fq[i].size() != 0) all_empty = 1'b0;
        end
        bus.data_in_p0 = 12'($urandom);
        bus.data_in_p1 = 12'($urandom);
        bus.data_in_p2 = 12'($urandom);
        bus.data_in_p3 = 12'($urandom);
        if (last_vld) begin
            case (last_port)
                0: bus.data_in_p0 = last_word;
                1: bus.data_in_p1 = last_word;
                2: bus.data_in_p2 = last_word;
                default: bus.data_in_p3 = last_word;
            endcase
        end
        #2;
        act_pop  = bus.pop;
        last_vld = 1'b0;
        if (reset) begin
            chk("pop_in_reset", 32'(act_pop), 32'd0);
            sb.delete();
            mptr     = 0;
            cnt      = '{default: 0};
            pend_req = 1'b0;
            pend_val = 0;
        end else begin
            exp_vld = (sb.size() > 0) && (sb[0].cyc <= cyc - 2);
            exp_acc = exp_vld && bus.ready_in;
            any = 1'b0;
            ep  = 0;
            for (int k = 0; k < 4; k++)
                if (!any && fq[(mptr + k) % 4].size() > 0) begin
                    any = 1'b1;
                    ep  = (mptr + k) % 4;
                end
            exp_pop = (enable && any && (sb.size() - int'(exp_acc)) < BUF_DEPTH) ? 4'(1 << ep) : 4'd0;
            chk("pop", 32'(act_pop), 32'(exp_pop));
            chk("valid_out", 32'(bus.valid_out), 32'(exp_vld));
            if (exp_vld) chk("data_out", 32'(bus.data_out), 32'(sb[0].word));
            chk("idle", 32'(idle), 32'(sb.size() == 0 && all_empty));
            chk("count_valid", 32'(count_valid), 32'(pend_req));
`ifdef EGRESS_PKT_COUNT_EN
            if (pend_req) chk("count_out", 32'(count_out), 32'(pend_val));
            pend_req = req;
            pend_val = cnt[idx];
`else
            chk("count_out_off", 32'(count_out), 32'd0);
            pend_req = 1'b0;
            pend_val = 0;
`endif
            if (exp_acc) begin
                cnt[sb[0].port] = (cnt[sb[0].port] + 1) % CNT_MOD;
                void'(sb.pop_front());
            end
            if (exp_pop != 4'd0) mptr = (ep + 1) % 4;
            // the FIFOs obey whatever the DUT actually popped
            if (act_pop != 4'd0) begin
                ap = 0;
                for (int k = 0; k < 4; k++) if (act_pop[k]) ap = k;
                last_word = (fq[ap].size() > 0) ? fq[ap].pop_front() : 12'hBAD;
                last_port = ap;
                last_vld  = 1'b1;
                sb.push_back('{word: last_word, port: ap, cyc: cyc});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset          = 1'b1;
        enable         = 1'b1;
        req            = 1'b0;
        idx            = 2'd0;
        bus.fifo_empty = 4'hF;
        bus.data_in_p0 = '0;
        bus.data_in_p1 = '0;
        bus.data_in_p2 = '0;
        bus.data_in_p3 = '0;
        bus.ready_in   = 1'b1;
        cnt            = '{default: 0};
        pend_req       = 1'b0;
        pend_val       = 0;
        last_vld       = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // reset state
        bus.fifo_empty = 4'hF;
        #1;
        chk("rst_pop", 32'(bus.pop), 32'd0);
        chk("rst_valid", 32'(bus.valid_out), 32'd0);
        chk("rst_dout", 32'(bus.data_out), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_cnt_out", 32'(count_out), 32'd0);
        chk("rst_cnt_vld", 32'(count_valid), 32'd0);

        // single port, two words
        fq[2].push_back(12'h0A1);
        fq[2].push_back(12'h0A2);
        run(6);

        // all ports loaded from pointer 0
        do_reset();
        for (int p = 0; p < 4; p++) load(p, 3);
        run(18);

        // sink stalls for six cycles with work pending
        for (int p = 0; p < 4; p++) load(p, 2);
        bus.ready_in = 1'b0;
        run(6);
        bus.ready_in = 1'b1;
        run(14);

        // reset one cycle after a pop; pointer must restart at 0
        do_reset();
        load(0, 2);
        load(2, 2);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        run(10);

        // enable low with one word buffered
        do_reset();
        load(3, 2);
        step();
        enable = 1'b0;
        run(6);
        enable = 1'b1;
        run(6);

        // randomized traffic, stalls, enable gaps, occasional reset
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                int p;
                p = $urandom_range(0, 3);
                if (fq[p].size() < 6) load(p, $urandom_range(1, 3));
            end
            bus.ready_in = ($urandom_range(0, 3) != 0);
            enable       = ($urandom_range(0, 9) != 0);
            reset        = ($urandom_range(0, 99) == 0);
            req          = $urandom_range(0, 1);
            idx          = 2'($urandom_range(0, 3));
            step();
        end
        reset        = 1'b0;
        enable       = 1'b1;
        bus.ready_in = 1'b1;
        req          = 1'b0;
        run(30);

        // 33 words from port 1, then read every counter
        do_reset();
        load(1, 33);
        run(40);
        for (int i = 0; i < 4; i++) begin
            req = 1'b1;
            idx = 2'(i);
            step();
        end
        req = 1'b0;
        run(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
